fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 98 +++++++++
 tb/tb_fifo_stream_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Streaming front end for a FIFO with registered read data.
// A two-entry skid buffer (head/tail) absorbs the one-cycle read latency, so
// the block keeps up with one word per cycle and never over-reads.
// flush drops buffered words and the word already on its way from the FIFO.

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy,
  output logic [15:0]           pop_count
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [1:0]            count_q;
  logic                  inflight_q;   // a read was issued last cycle; its word is on fifo_dout now
  logic                  discard_q;    // the word arriving this cycle belongs to a flushed stream
  logic [15:0]           pop_count_q;

  logic                  pop;
  logic                  capture;
  logic [2:0]            committed;    // words held plus words promised, after this cycle's pop

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign occupancy = count_q;
  assign pop_count = pop_count_q;

  assign pop = out_valid & out_ready;

  // A flush in the same cycle as an arrival wins: that word belongs to the
  // stream being thrown away.
  assign capture = inflight_q & ~discard_q & ~flush;

  // Only issue a read if the buffer is guaranteed a free slot when the word
  // lands, counting the word already in flight.
  assign committed  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_en = rst_n & ~fifo_empty & ~flush & (committed < 3'd2);

  // Buffer, counters and read-tracking state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data entries are reset too, so out_data reads 0 after reset
      // rather than stale words; this is a two-word buffer, not a RAM.
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      discard_q   <= 1'b0;
      pop_count_q <= 16'd0;
    end else begin
      // NOTE: every register here uses <= so all updates see the pre-edge
      // values of each other; blocking assignments would chain them.
      inflight_q <= fifo_rd_en;
      discard_q  <= flush;

      if (pop) begin
        pop_count_q <= pop_count_q + 16'd1;
      end

      if (flush) begin
        count_q <= 2'd0;
      end else begin
        unique case ({capture, pop})
          2'b10: begin
            if (count_q == 2'd0) head_q <= fifo_dout;
            else                 tail_q <= fifo_dout;
            count_q <= count_q + 2'd1;
          end
          2'b01: begin
            head_q  <= tail_q;
            count_q <= count_q - 2'd1;
          end
          2'b11: begin
            // Count holds; the arriving word goes behind whatever stays.
            if (count_q == 2'd2) begin
              head_q <= tail_q;
              tail_q <= fifo_dout;
            end else begin
              head_q <= fifo_dout;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural upstream FIFO, a queue-based
// scoreboard of words owed downstream, and directed plus random scenarios.

module tb_fifo_stream_reader;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          flush;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [15:0]   pop_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q[$];   // upstream FIFO contents
  logic [DW-1:0] exp_q[$];    // words popped from the FIFO and still owed downstream
  logic [DW-1:0] got_q[$];    // words seen by a directed collection window
  logic [15:0]   exp_cnt = 16'd0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .occupancy  (occupancy),
    .pop_count  (pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream FIFO: registered read data, valid the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
      check("occupancy_max", occupancy <= 2'd2, 1);
      check("valid_vs_occupancy", out_valid, occupancy != 2'd0);
      check("occupancy_window", (occupancy <= exp_q.size()) && (exp_q.size() <= occupancy + 1), 1);
      check("pop_count_model", pop_count, exp_cnt);
      if (prev_stall) check("stall_stable", out_data, prev_data);
      if (out_valid) begin
        check("order", out_data, (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'hx);
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (flush) exp_q.delete();
      if (fifo_rd_en && fifo_q.size() != 0) exp_q.push_back(fifo_q[0]);
    end else begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end
    prev_stall = rst_n & out_valid & ~out_ready & ~flush;
    prev_data  = out_data;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic collect(input int cycles);
    got_q.delete();
    repeat (cycles) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      step(1);
    end
  endtask

  // Feed n words (keeping the FIFO shallow) and wait until all are delivered.
  task automatic run_words(input int n, input int budget, input bit rand_ready);
    int sent = 0;
    int cyc  = 0;
    while ((sent < n || fifo_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      if (sent < n && fifo_q.size() < 8 && (!rand_ready || $urandom_range(0, 3) != 0)) begin
        push(DW'($urandom));
        sent++;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1);
      cyc++;
    end
    check("drain_timeout", cyc < budget, 1);
    out_ready = 1'b1;
    step(2);
  endtask

  initial begin
    logic [15:0] pc;
    int          rd_cnt;

    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    step(2);
    check("reset_valid", out_valid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_pop_count", pop_count, 0);
    check("reset_data", out_data, 0);
    check("reset_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;
    step(1);

    // Preloaded 1..5 with ready high: reads in cycles 0..4, data in 2..6.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push(DW'(i));
    #1;
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("burst_rd_en_c%0d", c), fifo_rd_en, c < 5);
      check($sformatf("burst_valid_c%0d", c), out_valid, (c >= 2) && (c <= 6));
      if (c >= 2 && c <= 6) check($sformatf("burst_data_c%0d", c), out_data, c - 1);
      step(1);
    end
    check("burst_pop_count", pop_count, 5);

    // Backpressure: only two reads, head held stable, then ordered drain.
    out_ready = 1'b0;
    push(32'hA); push(32'hB); push(32'hC);
    #1;
    rd_cnt = 0;
    repeat (6) begin
      if (fifo_rd_en) rd_cnt++;
      step(1);
    end
    check("bp_read_count", rd_cnt, 2);
    check("bp_occupancy", occupancy, 2);
    check("bp_head", out_data, 32'hA);
    step(1);
    check("bp_head_held", out_data, 32'hA);
    out_ready = 1'b1;
    collect(6);
    check("bp_drain_count", got_q.size(), 3);
    check("bp_drain_0", got_q[0], 32'hA);
    check("bp_drain_1", got_q[1], 32'hB);
    check("bp_drain_2", got_q[2], 32'hC);
    check("bp_pop_count", pop_count, 8);

    // Flush the cycle after a read: buffered and in-flight words vanish.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(DW'(32'h100 + i));
    #1;
    step(3);
    check("fl_full", occupancy, 2);
    check("fl_full_no_read", fifo_rd_en, 0);
    out_ready = 1'b1;
    #1;
    check("fl_read_on_pop", fifo_rd_en, 1);
    step(1);
    out_ready = 1'b0;
    flush     = 1'b1;
    pc        = pop_count;
    check("fl_occupancy_before", occupancy, 1);
    step(1);
    flush = 1'b0;
    check("fl_valid_low", out_valid, 0);
    check("fl_occupancy_zero", occupancy, 0);
    check("fl_pop_count_held", pop_count, pc);
    out_ready = 1'b1;
    collect(6);
    check("fl_survivor_count", got_q.size(), 1);
    check("fl_survivor", got_q.size() != 0 ? got_q[0] : 'x, 32'h103);

    // A pop in the flush cycle itself still counts.
    out_ready = 1'b0;
    push(32'h300); push(32'h301);
    #1;
    step(3);
    check("flp_full", occupancy, 2);
    out_ready = 1'b1;
    flush     = 1'b1;
    pc        = pop_count;
    step(1);
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("flp_pop_counted", pop_count, pc + 16'd1);
    check("flp_valid_low", out_valid, 0);
    step(2);

    // Reset mid-stream with a full buffer and a word left in the FIFO.
    push(32'h200); push(32'h201); push(32'h202);
    #1;
    step(4);
    check("rs_full", occupancy, 2);
    rst_n = 1'b0;
    #1;
    check("rs_rd_en_low", fifo_rd_en, 0);
    step(1);
    check("rs_valid", out_valid, 0);
    check("rs_pop_count", pop_count, 0);
    check("rs_occupancy", occupancy, 0);
    check("rs_rd_en_held", fifo_rd_en, 0);
    step(1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    collect(6);
    check("rs_resume_count", got_q.size(), 1);
    check("rs_resume_word", got_q.size() != 0 ? got_q[0] : 'x, 32'h202);
    check("rs_resume_pop_count", pop_count, 1);

    // Random words under random backpressure.
    pc = pop_count;
    run_words(1000, 20000, 1'b1);
    check("rand_pop_count", pop_count, pc + 16'd1000);

    // pop_count wrap.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    run_words(65534, 70000, 1'b0);
    check("wrap_pre", pop_count, 16'hFFFE);
    run_words(3, 100, 1'b0);
    check("wrap_post", pop_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
